// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sequencer slice.
package xadc_pkg;

  localparam int RESULT_W = 12;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DRDY,
    STORE
  } seq_state_t;

  localparam logic [6:0] DEF_ADDR_CH0 = 7'h1E;  // VAUX14
  localparam logic [6:0] DEF_ADDR_CH1 = 7'h17;  // VAUX7
  localparam logic [6:0] DEF_ADDR_CH2 = 7'h1F;  // VAUX15
  localparam logic [6:0] DEF_ADDR_CH3 = 7'h16;  // VAUX6

endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// XADC DRP port plus end-of-conversion strobe, seen from the sequencer (master) or the XADC (slave).
interface xadc_drp_if;

  logic [6:0]  daddr_out;
  logic        den_out;
  logic        dwe_out;
  logic [15:0] di_out;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        eoc_in;

  modport master (
    output daddr_out, den_out, dwe_out, di_out,
    input  drdy_in, do_in, eoc_in
  );

  modport slave (
    input  daddr_out, den_out, dwe_out, di_out,
    output drdy_in, do_in, eoc_in
  );

endinterface

// File: rtl/xadc_rr_pick.sv
// Combinational round-robin picker: first set bit of mask strictly after ptr, wrapping; ptr only as last resort.
module xadc_rr_pick
  import xadc_pkg::*;
(
  input  logic [CH_W-1:0]   ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   nxt,
  output logic              any
);

  // Walk from the farthest candidate (ptr itself) to the nearest so the nearest hit wins.
  always_comb begin
    nxt = ptr;
    any = |mask;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (mask[ptr + CH_W'(k)]) begin
        nxt = ptr + CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Round-robin DRP reader for the enabled XADC aux channels; one read per end-of-conversion.
// Optional XADC_SEQ_AVG_EN: publish the mean of every four samples per channel instead of each sample.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter logic [6:0]          ADDR_CH0       = DEF_ADDR_CH0,
  parameter logic [6:0]          ADDR_CH1       = DEF_ADDR_CH1,
  parameter logic [6:0]          ADDR_CH2       = DEF_ADDR_CH2,
  parameter logic [6:0]          ADDR_CH3       = DEF_ADDR_CH3,
  parameter int                  TIMEOUT_CYCLES = 64,
  parameter logic [RESULT_W-1:0] NOISE_MASK     = 12'hFF0
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [NUM_CH-1:0]            ch_en,
  xadc_drp_if.master                   drp,
  output logic [NUM_CH*RESULT_W-1:0]   result_flat,
  output logic [NUM_CH-1:0]            result_new,
  input  logic [NUM_CH-1:0]            rd_ack,
  output logic                         timeout_err,
  output logic                         busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  seq_state_t          state_reg;
  logic [CH_W-1:0]     ptr_reg;
  logic [6:0]          daddr_reg;
  logic                den_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_next;
  logic [RESULT_W-1:0] sample_reg;
  logic                timeout_reg;
  logic [CH_W-1:0]     pick_nxt;
  logic                pick_any;

  function automatic logic [6:0] addr_of(input logic [CH_W-1:0] ch);
    case (ch)
      2'd0:    addr_of = ADDR_CH0;
      2'd1:    addr_of = ADDR_CH1;
      2'd2:    addr_of = ADDR_CH2;
      default: addr_of = ADDR_CH3;
    endcase
  endfunction

  xadc_rr_pick u_pick (
    .ptr  (ptr_reg),
    .mask (ch_en),
    .nxt  (pick_nxt),
    .any  (pick_any)
  );

  assign cnt_next = cnt_reg + CNT_W'(1);

  // The channel selection, address and den are registered on the IDLE->ISSUE edge so den is high during ISSUE.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg   <= IDLE;
      ptr_reg     <= CH_W'(NUM_CH - 1);
      daddr_reg   <= ADDR_CH0;
      den_reg     <= 1'b0;
      cnt_reg     <= '0;
      sample_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          den_reg <= 1'b0;
          if (drp.eoc_in && pick_any) begin
            ptr_reg   <= pick_nxt;
            daddr_reg <= addr_of(pick_nxt);
            den_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          den_reg   <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT_DRDY;
        end
        WAIT_DRDY: begin
          cnt_reg <= cnt_next;
          if (drp.drdy_in) begin
            sample_reg <= drp.do_in[15:4] & NOISE_MASK;
            state_reg  <= STORE;
          end else if (cnt_next == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        STORE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign drp.daddr_out = daddr_reg;
  assign drp.den_out   = den_reg;
  assign drp.dwe_out   = 1'b0;
  assign drp.di_out    = 16'h0000;
  assign timeout_err   = timeout_reg;
  assign busy          = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [RESULT_W-1:0] res_reg;
      logic                new_reg;
      logic                store_hit;

      // A channel disabled mid-transaction drops its sample here.
      assign store_hit = (state_reg == STORE) && (ptr_reg == CH_W'(gi)) && ch_en[gi];

`ifdef XADC_SEQ_AVG_EN
      logic [RESULT_W+1:0] acc_reg;
      logic [1:0]          avg_cnt_reg;
      logic [RESULT_W+1:0] acc_sum;
      logic                publish;

      assign acc_sum = acc_reg + {2'b00, sample_reg};
      assign publish = store_hit && (avg_cnt_reg == 2'd3);

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          res_reg     <= '0;
          new_reg     <= 1'b0;
          acc_reg     <= '0;
          avg_cnt_reg <= '0;
        end else begin
          new_reg <= (new_reg & ~rd_ack[gi]) | publish;
          if (!ch_en[gi]) begin
            acc_reg     <= '0;
            avg_cnt_reg <= '0;
          end else if (store_hit) begin
            avg_cnt_reg <= avg_cnt_reg + 2'd1;
            if (publish) begin
              res_reg <= acc_sum[RESULT_W+1:2] & NOISE_MASK;
              acc_reg <= '0;
            end else begin
              acc_reg <= acc_sum;
            end
          end
        end
      end
`else
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          res_reg <= '0;
          new_reg <= 1'b0;
        end else begin
          new_reg <= (new_reg & ~rd_ack[gi]) | store_hit;
          if (store_hit) begin
            res_reg <= sample_reg;
          end
        end
      end
`endif

      assign result_flat[gi*RESULT_W +: RESULT_W] = res_reg;
      assign result_new[gi]                       = new_reg;
    end
  endgenerate

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer: table of round-robin reads plus timeout, mid-read disable and ack races.
module tb_xadc_drp_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic [47:0] result_flat;
  logic [3:0]  result_new;
  logic [3:0]  rd_ack;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  xadc_drp_if drp ();

  xadc_drp_sequencer dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .ch_en         (ch_en),
    .drp           (drp),
    .result_flat   (result_flat),
    .result_new    (result_new),
    .rd_ack        (rd_ack),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  en;
    logic [15:0] data;
    logic [6:0]  exp_addr;
    logic [47:0] exp_flat;
    logic [3:0]  exp_new;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One eoc-triggered transaction; caller is aligned 1 time unit after a rising edge.
  task automatic do_read(input logic [3:0] en, input logic [15:0] data, input bit respond,
                         input bit clear_mid, input bit ack_store,
                         output logic [6:0] addr_seen, output logic den_seen);
    ch_en       = en;
    drp.eoc_in  = 1'b1;
    tick();
    drp.eoc_in  = 1'b0;
    den_seen    = drp.den_out;
    addr_seen   = drp.daddr_out;
    if (clear_mid) ch_en = 4'b0000;
    if (respond) begin
      repeat (3) tick();
      drp.drdy_in = 1'b1;
      drp.do_in   = data;
      tick();
      drp.drdy_in = 1'b0;
      drp.do_in   = 16'h0000;
      if (ack_store) rd_ack = 4'b0001;
      tick();
      rd_ack = 4'b0000;
    end
  endtask

  initial begin
    vec_t       vecs [7];
    logic [6:0] a;
    logic       d;
    int         viol_den;
    int         viol_busy;
    int         k;

    vecs[0] = '{4'b1001, 16'hABCD, 7'h1E, 48'h000_000_000_AB0, 4'b0001};
    vecs[1] = '{4'b1001, 16'hABCD, 7'h16, 48'hAB0_000_000_AB0, 4'b1001};
    vecs[2] = '{4'b1001, 16'h1234, 7'h1E, 48'hAB0_000_000_120, 4'b1001};
    vecs[3] = '{4'b1001, 16'hFFFF, 7'h16, 48'hFF0_000_000_120, 4'b1001};
    vecs[4] = '{4'b0110, 16'h5678, 7'h17, 48'hFF0_000_560_120, 4'b1011};
    vecs[5] = '{4'b0110, 16'h0F0F, 7'h1F, 48'hFF0_0F0_560_120, 4'b1111};
    vecs[6] = '{4'b0100, 16'h4321, 7'h1F, 48'hFF0_430_560_120, 4'b1111};

    rst_n       = 1'b0;
    ch_en       = 4'b0000;
    rd_ack      = 4'b0000;
    drp.eoc_in  = 1'b0;
    drp.drdy_in = 1'b0;
    drp.do_in   = 16'h0000;
    repeat (3) tick();
    check("reset result_flat", 64'(result_flat), 64'h0);
    check("reset result_new", 64'(result_new), 64'h0);
    check("reset timeout_err", 64'(timeout_err), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset daddr", 64'(drp.daddr_out), 64'h1E);
    check("reset den", 64'(drp.den_out), 64'h0);
    check("dwe tied", 64'(drp.dwe_out), 64'h0);
    check("di tied", 64'(drp.di_out), 64'h0);
    rst_n = 1'b1;
    tick();

`ifndef XADC_SEQ_AVG_EN
    for (int i = 0; i < 7; i++) begin
      do_read(vecs[i].en, vecs[i].data, 1'b1, 1'b0, 1'b0, a, d);
      check($sformatf("vec%0d den", i), 64'(d), 64'h1);
      check($sformatf("vec%0d daddr", i), 64'(a), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d result_flat", i), 64'(result_flat), 64'(vecs[i].exp_flat));
      check($sformatf("vec%0d result_new", i), 64'(result_new), 64'(vecs[i].exp_new));
      check($sformatf("vec%0d busy", i), 64'(busy), 64'h0);
      check($sformatf("vec%0d den low after", i), 64'(drp.den_out), 64'h0);
    end
    rd_ack = 4'b1111;
    tick();
    rd_ack = 4'b0000;
    check("ack all result_new", 64'(result_new), 64'h0);
`endif

    // Enable mask empty: eoc must never start a transaction.
    ch_en      = 4'b0000;
    drp.eoc_in = 1'b1;
    viol_den   = 0;
    viol_busy  = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (drp.den_out) viol_den++;
      if (busy) viol_busy++;
    end
    drp.eoc_in = 1'b0;
    check("idle den cycles", 64'(viol_den), 64'h0);
    check("idle busy cycles", 64'(viol_busy), 64'h0);

    // No drdy ever: abort and flag after the timeout window.
    do_read(4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, a, d);
    check("timeout den", 64'(d), 64'h1);
    check("timeout daddr", 64'(a), 64'h1E);
    k = 0;
    while (!timeout_err && k < 100) begin
      tick();
      k++;
    end
    check("timeout cycles after den", 64'(k), 64'd64);
    check("timeout busy", 64'(busy), 64'h0);
    do_read(4'b0011, 16'h9990, 1'b1, 1'b0, 1'b0, a, d);
    check("post-timeout daddr", 64'(a), 64'h17);
    check("timeout_err sticky", 64'(timeout_err), 64'h1);
`ifndef XADC_SEQ_AVG_EN
    check("post-timeout result_flat", 64'(result_flat), 64'hFF0_430_990_120);
    check("post-timeout result_new", 64'(result_new), 64'h2);

    // Channel 2 disabled while its read is in flight: sample discarded.
    do_read(4'b0100, 16'hEEEE, 1'b1, 1'b1, 1'b0, a, d);
    check("midclear daddr", 64'(a), 64'h1F);
    check("midclear result_flat", 64'(result_flat), 64'hFF0_430_990_120);
    check("midclear result_new", 64'(result_new), 64'h2);

    // Ack on the store cycle loses to the set; a later ack clears.
    do_read(4'b0001, 16'hC3C3, 1'b1, 1'b0, 1'b1, a, d);
    check("ackrace daddr", 64'(a), 64'h1E);
    check("ackrace result_flat", 64'(result_flat), 64'hFF0_430_990_C30);
    check("ackrace result_new", 64'(result_new), 64'h3);
    rd_ack = 4'b0001;
    tick();
    rd_ack = 4'b0000;
    check("late ack result_new", 64'(result_new), 64'h2);
`else
    // Four reads of channel 1 averaged into one result.
    ch_en = 4'b0000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      do_read(4'b0010, 16'(i * 16'h1000), 1'b1, 1'b0, 1'b0, a, d);
      check($sformatf("avg read%0d daddr", i), 64'(a), 64'h17);
      if (i < 4) begin
        check($sformatf("avg read%0d result_new", i), 64'(result_new), 64'h0);
        check($sformatf("avg read%0d result_flat", i), 64'(result_flat), 64'h0);
      end
    end
    check("avg result_new", 64'(result_new), 64'h2);
    check("avg result_flat", 64'(result_flat), 64'h000_000_280_000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sequencer.md
Name: xadc_drp_sequencer

Overview:
- Upstream stage of the XADC user logic: owns the XADC DRP port and round-robins reads over the enabled auxiliary channels.
- Replaces the ad-hoc edge-triggered select/capture logic with a single-clock FSM that performs one DRP read per end-of-conversion.
- Presents a 12-bit, noise-masked result per channel to the LED PWM and AXI readback stages.

Parameters:
- ADDR_CH0, 7'h1E, DRP address of channel 0 (VAUX14)
- ADDR_CH1, 7'h17, DRP address of channel 1 (VAUX7)
- ADDR_CH2, 7'h1F, DRP address of channel 2 (VAUX15)
- ADDR_CH3, 7'h16, DRP address of channel 3 (VAUX6)
- TIMEOUT_CYCLES, 64, maximum cycles from den to drdy before abort
- NOISE_MASK, 12'hFF0, AND-mask applied to every 12-bit result

Ports:
- S_AXI_ACLK  in  1  single clock for all logic
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- ch_en  in  4  channel enable mask; from the AXI sw register
- eoc_in  in  1  XADC eoc_out
- drdy_in  in  1  XADC drdy_out
- do_in  in  16  XADC do_out
- daddr_out  out  7  DRP address
- den_out  out  1  DRP enable, one-cycle pulse
- dwe_out  out  1  DRP write enable, tied 0
- di_out  out  16  DRP write data, tied 0
- result_flat  out  48  {res3,res2,res1,res0}, 12 bits each
- result_new  out  4  sticky per-channel "fresh sample" flags
- rd_ack  in  4  per-channel clear for result_new
- timeout_err  out  1  sticky; set on DRP timeout, cleared by reset only
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=3, daddr_out=ADDR_CH0, den_out=0, result_flat=0, result_new=0, timeout_err=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT_DRDY, STORE.
- IDLE: on eoc_in=1 and ch_en!=0, nxt = first enabled channel strictly after ptr, wrapping 3->0; ptr itself is chosen only if it is the sole enabled channel. Go to ISSUE. When ch_en=0, stay in IDLE; den is never asserted.
- ISSUE (1 cycle): daddr_out=ADDR_CH[nxt]; den_out=1 this cycle only; ptr<=nxt; clear counter; go to WAIT_DRDY.
- WAIT_DRDY: counter increments each cycle.
  - drdy_in=1: latch sample = do_in[15:4] & NOISE_MASK; go to STORE.
  - counter reaches TIMEOUT_CYCLES-1 with no drdy: set timeout_err; go to IDLE; no store.
- STORE (1 cycle): if ch_en[ptr] is still 1, result[ptr]<=sample and result_new[ptr]<=1. If it was cleared mid-transaction, discard the sample. Go to IDLE.
- Only one DRP transaction is outstanding at a time. eoc_in outside IDLE is ignored and not queued.
- Latency: eoc_in in IDLE -> den_out at +1 cycle; drdy_in -> result_flat/result_new update at +2 cycles.
- result_new: rd_ack[i] clears bit i. A set and an ack on the same cycle leaves the bit 1 (set wins).
- daddr_out holds its last value outside ISSUE. dwe_out=0 and di_out=0 always.
- ch_en changes take effect at the next IDLE selection; an in-flight read always completes or times out.

Optional Feature:
- Macro: XADC_SEQ_AVG_EN.
- Defined:
  - Each channel has a 14-bit accumulator and a 2-bit count.
  - Each STORE adds the sample to the accumulator and increments the count.
  - When the count wraps from 3 to 0, result <= (acc+sample)>>2, masked with NOISE_MASK; result_new sets; accumulator clears.
  - Disabling a channel clears its accumulator and count.
  - Per-channel latency becomes 4 reads.
- Undefined: every STORE updates result directly, as described above.

Decomposition:
- Package xadc_pkg:
  - state enum (IDLE/ISSUE/WAIT_DRDY/STORE)
  - default channel address constants
  - RESULT_W=12 and NUM_CH=4
- One natural sub-module, xadc_rr_pick: combinational next-enabled-channel picker. Inputs ptr[1:0] and mask[3:0]; outputs nxt[1:0] and any.

Test Plan:
- ch_en=4'b1001, four eoc pulses, XADC model returns do=16'hABCD -> den addresses 1E,16,1E,16; res0=res3=12'hAB0; result_new=4'b1001.
- ch_en=0, eoc pulses for 200 cycles -> den_out never asserted; busy stays 0.
- DRP model never asserts drdy -> timeout_err=1 exactly 64 cycles after den; FSM returns to IDLE; next eoc issues the next channel.
- ch_en[2] cleared while reading channel 2 -> drdy arrives, res2 unchanged, result_new[2]=0.
- rd_ack[0] on the same cycle as a channel-0 store -> result_new[0]=1; ack one cycle later -> 0.
- XADC_SEQ_AVG_EN, channel 1 samples 12'h100,12'h200,12'h300,12'h400 -> result_new[1] set only after the 4th read, res1=12'h280.
